// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
interface instruction_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [31:0]       dina;

   modport master (
      output in_valid, in_data,
      input  in_ready, wea, addra, dina
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wea, addra, dina
   );
endinterface

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian 32-bit words,
// holding the CPU (busy) for the duration of the session.
module instruction_loader #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned START_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   instruction_loader_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam logic [ADDR_W-1:0] START     = ADDR_W'(START_ADDR);
   localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       part_q, part_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              in_ready_q, in_ready_d;
   logic              wea_q, wea_d;
   logic [ADDR_W-1:0] addra_q, addra_d;
   logic [31:0]       dina_q, dina_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              xfer;

   assign xfer = bus.in_valid && in_ready_q;

   // Next-state, datapath updates and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      part_d     = part_q;
      addr_d     = addr_q;
      addra_d    = addra_q;
      dina_d     = dina_q;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = LEN_HI;
               addr_d     = START;
               word_cnt_d = '0;
               byte_idx_d = '0;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d   = {bus.in_data, len_q[7:0]};
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d = {len_q[15:8], bus.in_data};
               if (len_d == 16'd0 || {1'b0, len_d} > MAX_WORDS) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               unique case (byte_idx_q)
                  2'd0: part_d[31:24] = bus.in_data;
                  2'd1: part_d[23:16] = bus.in_data;
                  2'd2: part_d[15:8]  = bus.in_data;
                  2'd3: part_d[7:0]   = bus.in_data;
                  default: ;
               endcase
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = WRITE;
                  addra_d = addr_q;
                  dina_d  = part_d;
               end
            end
         end
         WRITE: begin
            addr_d     = addr_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + 16'd1;
            byte_idx_d = '0;
            state_d    = (word_cnt_d == len_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
      wea_d      = (state_d == WRITE);
      busy_d     = in_ready_d || (state_d == WRITE);
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERR);
   end

   // State and output registers; reset wins over start and byte transfers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         part_q     <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         wea_q      <= 1'b0;
         addra_q    <= '0;
         dina_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         part_q     <= part_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
         wea_q      <= wea_d;
         addra_q    <= addra_d;
         dina_q     <= dina_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.wea      = wea_q;
   assign bus.addra    = addra_q;
   assign bus.dina     = dina_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: default instance at START_ADDR=0, second at 1023 for wrap.
module tb_instruction_loader;

   localparam int unsigned ADDR_W = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic vld = 1'b0;
   logic [7:0] dat = 8'h00;
   logic busy0, done0, error0;
   logic busy1, done1, error1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [ADDR_W-1:0] wa0[$];
   logic [31:0]       wd0[$];
   logic [ADDR_W-1:0] wa1[$];
   logic [31:0]       wd1[$];

   instruction_loader_if #(.ADDR_W(ADDR_W)) ifc ();
   instruction_loader_if #(.ADDR_W(ADDR_W)) ifw ();

   assign ifc.in_valid = vld;
   assign ifc.in_data  = dat;
   assign ifw.in_valid = vld;
   assign ifw.in_data  = dat;

   instruction_loader #(.ADDR_W(ADDR_W), .START_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start0), .bus(ifc),
      .busy(busy0), .done(done0), .error(error0)
   );

   instruction_loader #(.ADDR_W(ADDR_W), .START_ADDR(1023)) dut_w (
      .clk(clk), .reset(reset), .start(start1), .bus(ifw),
      .busy(busy1), .done(done1), .error(error1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ifc.wea === 1'b1) begin
         wa0.push_back(ifc.addra);
         wd0.push_back(ifc.dina);
      end
      if (ifw.wea === 1'b1) begin
         wa1.push_back(ifw.addra);
         wd1.push_back(ifw.dina);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   // Present one byte and hold it until the selected loader has taken it.
   task automatic send(input logic [7:0] b, input bit w);
      int i;
      vld = 1'b1;
      dat = b;
      i = 0;
      while (((w ? ifw.in_ready : ifc.in_ready) !== 1'b1) && i < 20) begin
         tick();
         i++;
      end
      if (i >= 20) timeout("send");
      tick();
      vld = 1'b0;
   endtask

   task automatic wait_done(input bit w, output int dcyc);
      int i;
      i = 0;
      dcyc = -1;
      while (((w ? done1 : done0) !== 1'b1) && i < 40) begin
         tick();
         i++;
      end
      if (i >= 40) timeout("wait_done");
      else dcyc = cyc;
   endtask

   task automatic pulse_start(input bit w);
      if (w) start1 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int s0;
   int dc;

   initial begin
      // Reset state.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("rst_wea",      64'(ifc.wea),      64'd0);
      chk("rst_addra",    64'(ifc.addra),    64'd0);
      chk("rst_dina",     64'(ifc.dina),     64'd0);
      chk("rst_busy",     64'(busy0),        64'd0);
      chk("rst_done",     64'(done0),        64'd0);
      chk("rst_error",    64'(error0),       64'd0);

      // Basic two-word load at full rate.
      wa0.delete(); wd0.delete();
      pulse_start(1'b0);
      s0 = cyc;
      chk("basic_busy_start", 64'(busy0), 64'd1);
      send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b0);
      send(8'h9A, 1'b0); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b0);
      chk("basic_busy_write", 64'(busy0), 64'd1);
      wait_done(1'b0, dc);
      chk("basic_done_cycle", 64'(dc - s0), 64'd12);
      chk("basic_busy_done",  64'(busy0),   64'd0);
      chk("basic_nwrites",    64'(wa0.size()), 64'd2);
      if (wa0.size() == 2) begin
         chk("basic_a0", 64'(wa0[0]), 64'd0);
         chk("basic_d0", 64'(wd0[0]), 64'h12345678);
         chk("basic_a1", 64'(wa0[1]), 64'd1);
         chk("basic_d1", 64'(wd0[1]), 64'h9ABCDEF0);
      end
      chk("basic_wea_idle", 64'(ifc.wea),   64'd0);
      chk("basic_dina_hold", 64'(ifc.dina), 64'h9ABCDEF0);
      chk("basic_addra_hold", 64'(ifc.addra), 64'd1);

      // Stalled stream: three idle cycles between bytes 2 and 3 of word 0.
      wa0.delete(); wd0.delete();
      pulse_start(1'b0);
      s0 = cyc;
      chk("stall_done_clr", 64'(done0), 64'd0);
      send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'h12, 1'b0); send(8'h34, 1'b0);
      tick(); tick(); tick();
      chk("stall_in_ready", 64'(ifc.in_ready), 64'd1);
      send(8'h56, 1'b0); send(8'h78, 1'b0);
      send(8'h9A, 1'b0); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b0);
      wait_done(1'b0, dc);
      chk("stall_done_cycle", 64'(dc - s0), 64'd15);
      chk("stall_nwrites", 64'(wa0.size()), 64'd2);
      if (wa0.size() == 2) begin
         chk("stall_d0", 64'(wd0[0]), 64'h12345678);
         chk("stall_a1", 64'(wa0[1]), 64'd1);
         chk("stall_d1", 64'(wd0[1]), 64'h9ABCDEF0);
      end

      // Start pulse while in DATA is ignored.
      wa0.delete(); wd0.delete();
      pulse_start(1'b0);
      s0 = cyc;
      send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'h12, 1'b0); send(8'h34, 1'b0);
      pulse_start(1'b0);
      send(8'h56, 1'b0); send(8'h78, 1'b0);
      send(8'h9A, 1'b0); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b0);
      wait_done(1'b0, dc);
      chk("sbusy_done_cycle", 64'(dc - s0), 64'd13);
      chk("sbusy_nwrites", 64'(wa0.size()), 64'd2);
      if (wa0.size() == 2) begin
         chk("sbusy_d0", 64'(wd0[0]), 64'h12345678);
         chk("sbusy_d1", 64'(wd0[1]), 64'h9ABCDEF0);
      end

      // Zero length aborts; bytes are refused in ERR.
      wa0.delete(); wd0.delete();
      pulse_start(1'b0);
      send(8'h00, 1'b0); send(8'h00, 1'b0);
      chk("len0_error",    64'(error0),       64'd1);
      chk("len0_busy",     64'(busy0),        64'd0);
      chk("len0_done",     64'(done0),        64'd0);
      vld = 1'b1; dat = 8'h55;
      tick(); tick();
      vld = 1'b0;
      chk("len0_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("len0_nwrites",  64'(wa0.size()),   64'd0);
      pulse_start(1'b0);
      chk("restart_error_clr", 64'(error0),       64'd0);
      chk("restart_in_ready",  64'(ifc.in_ready), 64'd1);

      // 1025 words exceeds a 1024-word memory.
      send(8'h04, 1'b0); send(8'h01, 1'b0);
      chk("len1025_error",   64'(error0),       64'd1);
      chk("len1025_ready",   64'(ifc.in_ready), 64'd0);
      chk("len1025_nwrites", 64'(wa0.size()),   64'd0);

      // Exactly 1024 words is legal.
      pulse_start(1'b0);
      send(8'h04, 1'b0); send(8'h00, 1'b0);
      chk("len1024_error", 64'(error0),       64'd0);
      chk("len1024_ready", 64'(ifc.in_ready), 64'd1);
      chk("len1024_busy",  64'(busy0),        64'd1);
      do_reset();

      // Reset after two bytes of word 1 discards it.
      wa0.delete(); wd0.delete();
      pulse_start(1'b0);
      send(8'h00, 1'b0); send(8'h02, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      send(8'h55, 1'b0); send(8'h66, 1'b0);
      chk("rmid_ready_pre", 64'(ifc.in_ready), 64'd1);
      do_reset();
      chk("rmid_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("rmid_wea",      64'(ifc.wea),      64'd0);
      chk("rmid_addra",    64'(ifc.addra),    64'd0);
      chk("rmid_dina",     64'(ifc.dina),     64'd0);
      chk("rmid_busy",     64'(busy0),        64'd0);
      chk("rmid_done",     64'(done0),        64'd0);
      chk("rmid_error",    64'(error0),       64'd0);
      tick(); tick();
      chk("rmid_nwrites", 64'(wa0.size()), 64'd1);
      if (wa0.size() == 1) chk("rmid_d0", 64'(wd0[0]), 64'h11223344);
      pulse_start(1'b0);
      send(8'h00, 1'b0); send(8'h01, 1'b0);
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
      wait_done(1'b0, dc);
      chk("rclean_nwrites", 64'(wa0.size()), 64'd2);
      if (wa0.size() == 2) begin
         chk("rclean_a", 64'(wa0[1]), 64'd0);
         chk("rclean_d", 64'(wd0[1]), 64'hAABBCCDD);
      end

      // Address wrap from 1023 to 0.
      wa1.delete(); wd1.delete();
      pulse_start(1'b1);
      send(8'h00, 1'b1); send(8'h02, 1'b1);
      send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
      send(8'h05, 1'b1); send(8'h06, 1'b1); send(8'h07, 1'b1); send(8'h08, 1'b1);
      wait_done(1'b1, dc);
      chk("wrap_nwrites", 64'(wa1.size()), 64'd2);
      if (wa1.size() == 2) begin
         chk("wrap_a0", 64'(wa1[0]), 64'd1023);
         chk("wrap_d0", 64'(wd1[0]), 64'h01020304);
         chk("wrap_a1", 64'(wa1[1]), 64'd0);
         chk("wrap_d1", 64'(wd1[1]), 64'h05060708);
      end
      chk("wrap_other_idle", 64'(wa0.size()), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
